param_sync_fifo: RTL and testbench
==================================

# param_sync_fifo

Parametrised single-clock synchronous FIFO, the successor to the 8-bit `wr_rd`/`full`/`empty` FIFO used by the write-channel BFM. It separates write and read enables and generalises width and depth. It adds occupancy count, programmable almost-full/almost-empty flags, and optional sticky overflow/underflow error capture. It sits between the AXI write-channel driver and the downstream consumer, and is the DUT for the fifo BFM agents.

## Interface
- `DATA_W`, default 8: data width in bits, ≥1.
- `DEPTH`, default 16: number of entries; power of two, ≥2.
- `AF_THRESH`, default `DEPTH-2`: `almost_full` asserts when count ≥ this value; range 1..DEPTH.
- `AE_THRESH`, default 2: `almost_empty` asserts when count ≤ this value; range 0..DEPTH-1.
- `clk` in 1: the only clock; all logic samples on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write request.
- `din` in DATA_W: write data.
- `rd_en` in 1: read request.
- `dout` out DATA_W: read data, registered.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: count ≥ AF_THRESH.
- `almost_empty` out 1: count ≤ AE_THRESH.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `clr_err` in 1: clears the sticky error flags.
- `overflow` out 1: sticky flag; a write was attempted while full.
- `underflow` out 1: sticky flag; a read was attempted while empty.

## Operation
- Write acceptance: a write is accepted iff `wr_en && !full`. Data is stored at `wr_ptr`, then `wr_ptr` increments.
- Read acceptance: a read is accepted iff `rd_en && !empty`. The word at `rd_ptr` is loaded into `dout`, then `rd_ptr` increments.
- `dout` holds its last value when no read is accepted.
- Pointers are ADDR_W = $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. `count` is tracked as a separate register.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when both or neither are accepted.
- Simultaneous write and read:
  - When full, only the read is accepted. The write is rejected and `overflow` sets.
  - When empty, only the write is accepted. The read is rejected and `underflow` sets; `dout` is unchanged.
  - In every other state, both are accepted.
- There is no write-through: data written in cycle N cannot be read before cycle N+1.
- Rejected requests never modify pointers, memory, `count` or `dout`.
- Reset values:
  - `count`, `wr_ptr`, `rd_ptr` = 0; `dout` = 0.
  - `empty` = 1, `full` = 0.
  - `almost_empty` = 1 (because AE_THRESH ≥ 0); `almost_full` = 0.
  - `overflow` = 0, `underflow` = 0.
- Memory contents are not reset.
- A reset asserted mid-operation discards all content and overrides any same-cycle `wr_en`/`rd_en`.
- All flags are registered and computed from the next-state count, so they are valid in the same cycle as the `count` they describe.

## Timing
- Write to visibility: a write in cycle N updates `count`/`empty` at edge N+1. The word is readable by a `rd_en` sampled at edge N+1.
- Read latency: `rd_en` accepted at edge N puts the data on `dout` after edge N, valid during cycle N+1.
- Flags change at the same edge as `count`. There are no combinational paths from inputs to outputs.
- Error flags:
  - `overflow`/`underflow` set at the edge following the offending request.
  - `clr_err` clears them at the next edge.
  - If `clr_err` and a new error occur in the same cycle, the flag stays set (set wins).
- Full throughput: one write and one read per cycle, sustained indefinitely at any 0 < count < DEPTH.

## Configuration
- Macro: `FIFO_ERR_FLAGS_EN`.
- Defined: the sticky `overflow`/`underflow` registers and `clr_err` behave as specified above.
- Undefined:
  - `overflow` and `underflow` are tied to 0.
  - `clr_err` is ignored.
  - The port list is unchanged.
  - Request rejection at full and empty is identical in both builds.

## Structure
- Shared package `fifo_pkg`:
  - `fifo_status_t`, a packed struct of {full, empty, almost_full, almost_empty, overflow, underflow}.
  - Function `cnt_w(depth)` returning $clog2(depth)+1.
  - The BFM interface and monitor import this package.
- Sub-module `fifo_ram`: a simple dual-port register array (DEPTH × DATA_W) with a synchronous write port and a synchronous registered read port.
- Control logic (pointers, count, flags, error capture) lives in `param_sync_fifo`.
- Parameter legality is checked by elaboration-time assertions: DEPTH is a power of two, and the thresholds are in range.

## Test plan
- Reset, then idle 5 cycles → `empty`=1, `almost_empty`=1, `count`=0, `dout`=0, all other flags 0.
- DEPTH=16: write 0x01..0x10 back-to-back.
  - `almost_full` rises when `count` reaches 14.
  - `full` rises after the 16th write.
  - A 17th write with 0xFF → `overflow`=1, `count` stays 16.
- Read all 16 entries → `dout` sequence 0x01..0x10, each one cycle after its `rd_en`.
  - `empty`=1 after the last read.
  - An extra `rd_en` → `underflow`=1, `dout` holds 0x10.
- Simultaneous `wr_en`/`rd_en` for 40 cycles at `count`=5 → `count` stays 5; the output order matches the input order across pointer wrap-around.
- Simultaneous `wr_en`/`rd_en` at full → only the read is accepted, `count` becomes 15, `overflow`=1. Then assert `clr_err` → flags clear the next cycle.
- Fill to 8 entries, then assert `rst` together with `wr_en` → the next cycle shows `count`=0, `empty`=1, and the written data is discarded. Build without `FIFO_ERR_FLAGS_EN` → `overflow`/`underflow` are never 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO status type and count-width helper for the RTL, BFM interface and monitor.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W dual-port register array, synchronous write, registered read (read register resets to 0).
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with occupancy count and almost flags;
// sticky overflow/underflow capture is built only when FIFO_ERR_FLAGS_EN is defined.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       din,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       dout,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [cnt_w(DEPTH)-1:0] count,
    input  logic                    clr_err,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CW     = cnt_w(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic              wr_ok, rd_ok;
    fifo_status_t      st, st_nxt;

    assign wr_ok = wr_en && !st.full;
    assign rd_ok = rd_en && !st.empty;

    // Flags are derived from the next count so they land on the same edge as count.
    always_comb begin
        count_nxt           = count + CW'(wr_ok) - CW'(rd_ok);
        st_nxt.full         = count_nxt == CW'(DEPTH);
        st_nxt.empty        = count_nxt == '0;
        st_nxt.almost_full  = count_nxt >= CW'(AF_THRESH);
        st_nxt.almost_empty = count_nxt <= CW'(AE_THRESH);
`ifdef FIFO_ERR_FLAGS_EN
        st_nxt.overflow     = (wr_en && st.full) || (st.overflow && !clr_err);
        st_nxt.underflow    = (rd_en && st.empty) || (st.underflow && !clr_err);
`else
        st_nxt.overflow     = 1'b0;
        st_nxt.underflow    = 1'b0;
`endif
    end

`ifndef FIFO_ERR_FLAGS_EN
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            st     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
                        overflow: 1'b0, underflow: 1'b0};
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count_nxt;
            st    <= st_nxt;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (dout)
    );

    assign full         = st.full;
    assign empty        = st.empty;
    assign almost_full  = st.almost_full;
    assign almost_empty = st.almost_empty;
    assign overflow     = st.overflow;
    assign underflow    = st.underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: queue-based reference model compared every cycle, plus directed and random stimulus.
module tb_param_sync_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int AE     = 2;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic              full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]        count;

    param_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit en_chk = 1'b0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout = '0;
    bit m_ovf = 1'b0, m_udf = 1'b0;
    bit wa, ra;

    // Reference: an ideal queue of at most DEPTH words.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            wa = wr_en && q.size() < DEPTH;
            ra = rd_en && q.size() > 0;
            m_ovf = ERR_EN && ((wr_en && !wa) || (m_ovf && !clr_err));
            m_udf = ERR_EN && ((rd_en && !ra) || (m_udf && !clr_err));
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(din);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (en_chk) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
            chk("dout", 32'(dout), 32'(m_dout));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_udf));
        end
    end

    task automatic cyc(input bit w, input logic [DATA_W-1:0] d, input bit r, input bit c);
        wr_en = w; din = d; rd_en = r; clr_err = c;
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        en_chk = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        chk("lit_reset_count", 32'(count), 0);
        chk("lit_reset_empty", 32'(empty), 1);
        chk("lit_reset_ae", 32'(almost_empty), 1);
        chk("lit_reset_dout", 32'(dout), 0);

        for (int i = 1; i <= 16; i++) begin
            cyc(1, DATA_W'(i), 0, 0);
            if (i == 13) chk("lit_af_at_13", 32'(almost_full), 0);
            if (i == 14) chk("lit_af_at_14", 32'(almost_full), 1);
            if (i == 15) chk("lit_full_at_15", 32'(full), 0);
        end
        chk("lit_full", 32'(full), 1);
        cyc(1, 8'hFF, 0, 0);
        chk("lit_ovf_count", 32'(count), 16);
        chk("lit_ovf", 32'(overflow), 32'(ERR_EN));

        for (int i = 1; i <= 16; i++) begin
            cyc(0, 0, 1, 0);
            chk("lit_read_seq", 32'(dout), 32'(i));
        end
        chk("lit_empty_after", 32'(empty), 1);
        cyc(0, 0, 1, 0);
        chk("lit_udf", 32'(underflow), 32'(ERR_EN));
        chk("lit_udf_dout_hold", 32'(dout), 32'h10);
        cyc(0, 0, 0, 1);
        chk("lit_clr_ovf", 32'(overflow), 0);
        chk("lit_clr_udf", 32'(underflow), 0);

        for (int i = 0; i < 5; i++) cyc(1, DATA_W'(8'hA0 + i), 0, 0);
        for (int i = 0; i < 40; i++) cyc(1, DATA_W'($urandom), 1, 0);
        chk("lit_steady_count", 32'(count), 5);

        while (!full) cyc(1, DATA_W'($urandom), 0, 0);
        cyc(1, 8'h55, 1, 0);
        chk("lit_both_full_count", 32'(count), 15);
        chk("lit_both_full_ovf", 32'(overflow), 32'(ERR_EN));
        cyc(0, 0, 0, 1);
        chk("lit_clr_after_full", 32'(overflow), 0);

        // Set-wins: clear together with a fresh error.
        while (!full) cyc(1, DATA_W'($urandom), 0, 0);
        cyc(1, 8'h11, 0, 1);
        chk("lit_set_wins", 32'(overflow), 32'(ERR_EN));

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 99) < 55, DATA_W'($urandom), $urandom_range(0, 99) < 50,
                $urandom_range(0, 15) == 0);
        end
        rst = 1'b0;

        cyc(0, 0, 0, 0);
        while (count > 0) cyc(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, DATA_W'(8'hC0 + i), 0, 0);
        chk("lit_fill8", 32'(count), 8);
        rst = 1'b1;
        cyc(1, 8'hEE, 0, 0);
        rst = 1'b0;
        chk("lit_rst_count", 32'(count), 0);
        chk("lit_rst_empty", 32'(empty), 1);
        cyc(0, 0, 1, 0);
        chk("lit_rst_discard", 32'(dout), 0);
        chk("lit_rst_discard_count", 32'(count), 0);

        cyc(0, 0, 0, 0);
        en_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
